alu8_serial: RTL
================

ALU8_SERIAL -- requirements
Module: alu8_serial

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits; one bit is processed per clock.
REQ-002 CLK  input  1  sole clock; all state updates on the rising edge.
REQ-003 RST_N  input  1  reset, asynchronous, active-low.
REQ-004 Start  input  1  request; sampled only when Ready=1.
REQ-005 Ready  output  1  high when a Start will be accepted.
REQ-006 Mode  input  3  op select: 000 plus, 001 AND, 010 OR, 011 XOR, 100 XNOR, 101-111 reserved.
REQ-007 A  input  WIDTH  operand A.
REQ-008 B  input  WIDTH  operand B.
REQ-009 C_in  input  1  carry-in for plus mode; ignored for other modes.
REQ-010 X  output  WIDTH  result, held stable between completions.
REQ-011 C_out  output  1  carry out of bit WIDTH-1 in plus mode; 0 for all other modes.
REQ-012 Done  output  1  single-cycle pulse marking X/C_out updated.
REQ-013 Busy  output  1  high while an operation is in progress.

Function
REQ-014 The block SHALL be a bit-serial ALU with an FSM of three states: IDLE, RUN, DONE.
REQ-015 IDLE: Ready=1, Busy=0; on Start=1, capture Mode, A, B, C_in into internal registers, clear bit counter, go to RUN.
REQ-016 RUN: Ready=0, Busy=1; each cycle, process bit i (LSB first, i=0..WIDTH-1) through one 1-bit slice, shift result bit into a result shift register, update the carry flop, increment the counter.
REQ-017 Carry flop SHALL load captured C_in for plus mode and 0 for all other modes at capture.
REQ-018 After bit WIDTH-1 is processed, the state SHALL go to DONE and, on the same edge, load X from the shift register and C_out from the final carry (forced 0 unless Mode=000).
REQ-019 DONE: Done=1 for exactly one cycle, Busy=0, Ready=1; a Start sampled in DONE is accepted exactly as in IDLE (back-to-back); otherwise go to IDLE.
REQ-020 Latency: Start sampled at edge k means X/C_out are valid and Done=1 in the cycle after edge k+WIDTH; throughput is one operation per WIDTH+1 cycles.
REQ-021 Changes on Mode, A, B, C_in after capture SHALL NOT affect the operation in progress.
REQ-022 Start while Ready=0 SHALL be ignored, not queued.
REQ-023 Reserved Mode values SHALL yield X=0 and C_out=0 with normal timing and Done pulse.
REQ-024 Plus SHALL wrap modulo 2^WIDTH, overflow reported only through C_out.
REQ-025 X and C_out SHALL change only on the edge entering DONE, never during RUN.

Reset
REQ-026 RST_N low SHALL immediately force state IDLE, X=0, C_out=0, Done=0, Busy=0, Ready=1, counter and carry to 0.
REQ-027 Reset during RUN SHALL abort the operation with no Done pulse; the first Start after release starts a fresh operation.
REQ-028 Start SHALL NOT be sampled on the first edge at which RST_N is already high only if it is sampled in IDLE; no other reset sequencing is required.

Structure
REQ-029 A shared package SHALL hold the Mode encodings (PLUS, AND, OR, XOR, XNOR) and the FSM state type, shared with the parallel ALU and future controllers.
REQ-030 One sub-module SHALL be instantiated: the existing 1-bit slice ALU (Mode, A, B, C_in, X, C_out); the top-level SHALL force carry to 0 for non-plus modes regardless of slice carry behaviour.
REQ-031 Counter width SHALL be clog2(WIDTH)+1 bits; no other arithmetic beyond the slice.

Verification
REQ-032 Plus: A=0xFF, B=0x01, C_in=0 -> X=0x00, C_out=1, Done exactly 9 cycles after the Start edge.
REQ-033 Plus with carry: A=0x7F, B=0x00, C_in=1 -> X=0x80, C_out=0; AND A=0xF0, B=0x3C -> X=0x30, C_out=0 even with C_in=1.
REQ-034 XNOR A=0xA5, B=0x0F -> X=0x55; Mode=101 with A=B=0xFF -> X=0x00, C_out=0, Done still pulses.
REQ-035 Start held high with A changed to 0x00 mid-RUN, Mode=010, A=0x12, B=0x21 -> X=0x33; Start re-sampled only in DONE, second op completes 9 cycles later.
REQ-036 RST_N pulsed low at RUN bit 4 of A=0xFF+B=0x01 -> X=0x00, no Done, Ready=1 immediately; following op A=0x03+B=0x04 -> X=0x07.

Source files
------------

// File: rtl/alu8_serial_pkg.sv
// rtl/alu8_serial_pkg.sv - mode encodings and FSM state type shared by the ALU family
package alu8_serial_pkg;

  localparam logic [2:0] MODE_PLUS = 3'b000;
  localparam logic [2:0] MODE_AND  = 3'b001;
  localparam logic [2:0] MODE_OR   = 3'b010;
  localparam logic [2:0] MODE_XOR  = 3'b011;
  localparam logic [2:0] MODE_XNOR = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu8_serial_slice.sv
// rtl/alu8_serial_slice.sv - 1-bit ALU slice; reserved modes produce 0 on both outputs
module alu8_serial_slice (
  input  logic [2:0] mode,
  input  logic       a,
  input  logic       b,
  input  logic       c_in,
  output logic       x,
  output logic       c_out
);
  import alu8_serial_pkg::*;

  always_comb begin
    x     = 1'b0;
    c_out = 1'b0;
    case (mode)
      MODE_PLUS: begin
        x     = a ^ b ^ c_in;
        c_out = (a & b) | (c_in & (a ^ b));
      end
      MODE_AND:  x = a & b;
      MODE_OR:   x = a | b;
      MODE_XOR:  x = a ^ b;
      MODE_XNOR: x = ~(a ^ b);
      default: begin
        x     = 1'b0;
        c_out = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu8_serial.sv
// rtl/alu8_serial.sv - bit-serial ALU, LSB first, one bit per clock through a shared 1-bit slice
module alu8_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             ready,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH-1:0] x,
  output logic             c_out,
  output logic             done,
  output logic             busy
);
  import alu8_serial_pkg::*;

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_t             state, state_next;
  logic [2:0]         mode_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic               carry_q;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-2:0]   sr;
  logic               slice_x, slice_c;
  logic               accept, last_bit, carry_next;

  alu8_serial_slice u_slice (
    .mode  (mode_q),
    .a     (a_q[0]),
    .b     (b_q[0]),
    .c_in  (carry_q),
    .x     (slice_x),
    .c_out (slice_c)
  );

  assign last_bit   = (cnt == CNT_W'(WIDTH - 1));
  // Carry is masked here so a slice that leaks carry in logic modes cannot corrupt c_out.
  assign carry_next = (mode_q == MODE_PLUS) & slice_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    case (state)
      ST_IDLE: begin
        ready = 1'b1;
        if (start) begin
          accept     = 1'b1;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (last_bit) state_next = ST_DONE;
      end
      ST_DONE: begin
        done  = 1'b1;
        ready = 1'b1;
        if (start) begin
          accept     = 1'b1;
          state_next = ST_RUN;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
      sr      <= '0;
      x       <= '0;
      c_out   <= 1'b0;
    end else if (accept) begin
      mode_q  <= mode;
      a_q     <= a;
      b_q     <= b;
      carry_q <= (mode == MODE_PLUS) & c_in;
      cnt     <= '0;
    end else if (state == ST_RUN) begin
      a_q     <= a_q >> 1;
      b_q     <= b_q >> 1;
      carry_q <= carry_next;
      cnt     <= cnt + CNT_W'(1);
      sr      <= {slice_x, sr[WIDTH-2:1]};
      if (last_bit) begin
        x     <= {slice_x, sr};
        c_out <= carry_next;
      end
    end
  end

endmodule
